pc_update_ctrl: RTL and testbench



---
 rtl/pc_update_ctrl_pkg.sv | 72 +++++++
 rtl/pc_update_ctrl_exc_vec_sel.sv | 26 ++
 rtl/pc_update_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_update_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_update_ctrl_pkg.sv
// Shared definitions for the PC-update sequencer: state encoding, request
// and cause codes, PC-source mux codes, and the normal-update decoder.
package pc_update_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UPD      = 3'd1,
        ST_EXC_SAVE = 3'd2,
        ST_EXC_READ = 3'd3,
        ST_EXC_LOAD = 3'd4
    } state_t;

    // Normal PC-update request types
    localparam logic [1:0] REQ_SEQ    = 2'd0;
    localparam logic [1:0] REQ_BRANCH = 2'd1;
    localparam logic [1:0] REQ_JUMP   = 2'd2;
    localparam logic [1:0] REQ_RTE    = 2'd3;

    // Exception cause codes (3 is reserved and handled like an invalid opcode)
    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_RSVD   = 2'd3;

    // PC-source mux select codes
    localparam logic [2:0] PCSRC_ALU    = 3'b000;
    localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_VECTOR = 3'b011;
    localparam logic [2:0] PCSRC_EPC    = 3'b100;

    // Mux select plus write enable for a one-cycle PC update
    typedef struct packed {
        logic [2:0] src;
        logic       wr;
    } pc_upd_t;

    // Maps a normal request to its UPD-cycle outputs. A not-taken branch
    // writes nothing, and the select is parked at ALU so it is never
    // left pointing somewhere meaningful without a write.
    function automatic pc_upd_t decode_upd(input logic [1:0] req_type,
                                           input logic       br_taken);
        pc_upd_t upd;
        upd.src = PCSRC_ALU;
        upd.wr  = 1'b1;
        case (req_type)
            REQ_SEQ: begin
                upd.src = PCSRC_ALU;
                upd.wr  = 1'b1;
            end
            REQ_BRANCH: begin
                upd.src = br_taken ? PCSRC_ALUOUT : PCSRC_ALU;
                upd.wr  = br_taken;
            end
            REQ_JUMP: begin
                upd.src = PCSRC_JUMP;
                upd.wr  = 1'b1;
            end
            REQ_RTE: begin
                upd.src = PCSRC_EPC;
                upd.wr  = 1'b1;
            end
            default: begin
                upd.src = PCSRC_ALU;
                upd.wr  = 1'b0;
            end
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/pc_update_ctrl_exc_vec_sel.sv
// Exception vector address selector: turns a cause code into the memory
// byte address holding that cause's handler vector.
module pc_update_ctrl_exc_vec_sel
    import pc_update_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic [1:0]  cause,
    output logic [31:0] vec_addr
);

    // Cause to vector lookup; the reserved code falls back to the opcode vector
    always_comb begin
        vec_addr = VEC_OPCODE;
        case (cause)
            CAUSE_OPCODE: vec_addr = VEC_OPCODE;
            CAUSE_OVF:    vec_addr = VEC_OVF;
            CAUSE_DIV0:   vec_addr = VEC_DIV0;
            CAUSE_RSVD:   vec_addr = VEC_OPCODE;
            default:      vec_addr = VEC_OPCODE;
        endcase
    end

endmodule

// File: rtl/pc_update_ctrl.sv
// PC-update sequencer for the multicycle core. Issues one-cycle PC loads for
// sequential/branch/jump/RTE requests, and runs exception entry: save EPC,
// fetch the handler vector over MEM_LAT cycles, then load PC from it.
module pc_update_ctrl
    import pc_update_ctrl_pkg::*;
#(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_type,
    input  logic        br_taken,
    output logic        req_ready,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    output logic [2:0]  PC_src,
    output logic        PC_write,
    output logic        EPC_write,
    output logic        vec_rd,
    output logic [31:0] vec_addr,
    output logic [1:0]  cause_q,
    output logic        busy,
    output logic        done
);

    // A zero-latency memory cannot be sequenced; refuse to elaborate.
    generate
        if (MEM_LAT < 1) begin : g_bad_mem_lat
            $error("pc_update_ctrl: MEM_LAT must be at least 1");
        end
    endgenerate

    // Counter sized to hold MEM_LAT-1 down to 0; guarded so a bad MEM_LAT
    // still reaches the error above instead of a zero-width vector.
    localparam int              CNT_W    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] lat_cnt_reg;
    pc_upd_t          upd_dec;
    logic [31:0]      sel_addr;

    // Vector address follows the latched cause, which is stable from EXC_SAVE on
    pc_update_ctrl_exc_vec_sel #(
        .VEC_OPCODE (VEC_OPCODE),
        .VEC_OVF    (VEC_OVF),
        .VEC_DIV0   (VEC_DIV0)
    ) u_exc_vec_sel (
        .cause    (cause_q),
        .vec_addr (sel_addr)
    );

    // Decode of the pending normal request; only consumed at the accept edge,
    // so later changes of br_taken have no effect.
    assign upd_dec = decode_upd(req_type, br_taken);

    // Exceptions take priority: a normal request is refused while exc_req is up.
    assign req_ready = (state_reg == ST_IDLE) && !exc_req;

    // Sequencer: state, latency counter and all registered outputs. Strobe
    // outputs default low each cycle so PC_src parks at ALU whenever no
    // write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            lat_cnt_reg <= '0;
            PC_src      <= PCSRC_ALU;
            PC_write    <= 1'b0;
            EPC_write   <= 1'b0;
            vec_rd      <= 1'b0;
            vec_addr    <= '0;
            cause_q     <= CAUSE_OPCODE;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            PC_src    <= PCSRC_ALU;
            PC_write  <= 1'b0;
            EPC_write <= 1'b0;
            vec_rd    <= 1'b0;
            vec_addr  <= '0;
            done      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (exc_req) begin
                        state_reg <= ST_EXC_SAVE;
                        EPC_write <= 1'b1;
                        cause_q   <= exc_cause;
                        busy      <= 1'b1;
                    end else if (req_valid) begin
                        state_reg <= ST_UPD;
                        PC_src    <= upd_dec.src;
                        PC_write  <= upd_dec.wr;
                        done      <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        busy      <= 1'b0;
                    end
                end

                ST_UPD: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end

                ST_EXC_SAVE: begin
                    state_reg   <= ST_EXC_READ;
                    vec_rd      <= 1'b1;
                    vec_addr    <= sel_addr;
                    lat_cnt_reg <= LAT_INIT;
                    busy        <= 1'b1;
                end

                ST_EXC_READ: begin
                    busy <= 1'b1;
                    if (lat_cnt_reg == '0) begin
                        // Vector data is valid now; load it into PC next cycle
                        state_reg <= ST_EXC_LOAD;
                        PC_src    <= PCSRC_VECTOR;
                        PC_write  <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        vec_rd      <= 1'b1;
                        vec_addr    <= sel_addr;
                        lat_cnt_reg <= lat_cnt_reg - CNT_W'(1);
                    end
                end

                ST_EXC_LOAD: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed bench for pc_update_ctrl with MEM_LAT=3. Stimulus pushes the
// expected output cycles into a scoreboard; a negedge monitor pops and
// compares whenever the DUT drives any strobe.
module tb_pc_update_ctrl;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_type;
    logic        br_taken;
    logic        req_ready;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [2:0]  PC_src;
    logic        PC_write;
    logic        EPC_write;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic [1:0]  cause_q;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  src;
        logic        pcw;
        logic        epcw;
        logic        vrd;
        logic [31:0] addr;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    pc_update_ctrl #(
        .MEM_LAT    (L),
        .VEC_OPCODE (32'd253),
        .VEC_OVF    (32'd254),
        .VEC_DIV0   (32'd255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_type  (req_type),
        .br_taken  (br_taken),
        .req_ready (req_ready),
        .exc_req   (exc_req),
        .exc_cause (exc_cause),
        .PC_src    (PC_src),
        .PC_write  (PC_write),
        .EPC_write (EPC_write),
        .vec_rd    (vec_rd),
        .vec_addr  (vec_addr),
        .cause_q   (cause_q),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [2:0] s, input logic pcw,
                            input logic epcw, input logic vrd,
                            input logic [31:0] a, input logic dn);
        exp_t e;
        e.cyc = c; e.src = s; e.pcw = pcw; e.epcw = epcw;
        e.vrd = vrd; e.addr = a; e.dn = dn;
        sb_q.push_back(e);
    endtask

    // Monitor: any strobe activity is a transaction to match against the scoreboard
    always @(negedge clk) begin
        if (PC_write === 1'b1 || EPC_write === 1'b1 || vec_rd === 1'b1 || done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d src=%b pcw=%b epcw=%b vrd=%b addr=%0d done=%b",
                         cyc, PC_src, PC_write, EPC_write, vec_rd, vec_addr, done);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc != cyc || PC_src !== mon_e.src || PC_write !== mon_e.pcw ||
                    EPC_write !== mon_e.epcw || vec_rd !== mon_e.vrd ||
                    vec_addr !== mon_e.addr || done !== mon_e.dn) begin
                    errors++;
                    $display("FAIL txn actual cyc=%0d src=%b pcw=%b epcw=%b vrd=%b addr=%0d done=%b expected cyc=%0d src=%b pcw=%b epcw=%b vrd=%b addr=%0d done=%b",
                             cyc, PC_src, PC_write, EPC_write, vec_rd, vec_addr, done,
                             mon_e.cyc, mon_e.src, mon_e.pcw, mon_e.epcw, mon_e.vrd, mon_e.addr, mon_e.dn);
                end else begin
                    $display("txn cyc=%0d src=%b pcw=%b epcw=%b vrd=%b addr=%0d done=%b ok",
                             cyc, PC_src, PC_write, EPC_write, vec_rd, vec_addr, done);
                end
            end
        end
    end

    // Hold a normal request until accepted, then push its single UPD-cycle result
    task automatic send_req(input logic [1:0] rt, input logic br,
                            input logic [2:0] exp_src, input logic exp_wr,
                            output int acc);
        int n;
        req_valid = 1'b1;
        req_type  = rt;
        br_taken  = br;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        acc = cyc;
        chk("req_accept", {31'd0, req_ready}, 32'd1);
        push_exp(acc + 1, exp_src, exp_wr, 1'b0, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        br_taken  = ~br;
        chk("busy_upd", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    // Raise an exception from IDLE and push the full EPC/vector/load sequence
    task automatic send_exc(input logic [1:0] cause, input logic [31:0] addr,
                            output int acc);
        exc_req   = 1'b1;
        exc_cause = cause;
        #1;
        chk("ready_low_on_exc", {31'd0, req_ready}, 32'd0);
        acc = cyc;
        push_exp(acc + 1, 3'b000, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < L; k++)
            push_exp(acc + 2 + k, 3'b000, 1'b0, 1'b0, 1'b1, addr, 1'b0);
        push_exp(acc + 2 + L, 3'b011, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        exc_req = 1'b0;
        wait_idle();
        chk("cause_q", {30'd0, cause_q}, {30'd0, cause});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, ae;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_type  = 2'd0;
        br_taken  = 1'b0;
        exc_req   = 1'b0;
        exc_cause = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc_src",   {29'd0, PC_src},    32'd0);
        chk("rst_pc_write", {31'd0, PC_write},  32'd0);
        chk("rst_epc",      {31'd0, EPC_write}, 32'd0);
        chk("rst_vec_rd",   {31'd0, vec_rd},    32'd0);
        chk("rst_vec_addr", vec_addr,           32'd0);
        chk("rst_cause_q",  {30'd0, cause_q},   32'd0);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // 1: sequential update
        send_req(2'd0, 1'b0, 3'b000, 1'b1, a1);
        wait_idle();
        chk("seq_done_cleared", {31'd0, done}, 32'd0);

        // 2: branch taken, then not taken (done still pulses)
        send_req(2'd1, 1'b1, 3'b001, 1'b1, a1);
        wait_idle();
        send_req(2'd1, 1'b0, 3'b000, 1'b0, a1);
        wait_idle();

        // 3: jump then RTE held back-to-back; exactly one idle cycle between
        send_req(2'd2, 1'b0, 3'b010, 1'b1, a1);
        send_req(2'd3, 1'b0, 3'b100, 1'b1, a2);
        chk("jump_rte_gap", a2 - a1, 32'd2);
        wait_idle();

        // 4: overflow exception, MEM_LAT=3
        send_exc(2'd1, 32'd254, ae);

        // 5: exception and jump together: exception first, jump after
        req_valid = 1'b1;
        req_type  = 2'd2;
        send_exc(2'd2, 32'd255, ae);
        send_req(2'd2, 1'b0, 3'b010, 1'b1, a1);
        chk("jump_after_exc", a1 - ae, 32'(3 + L));
        wait_idle();

        // Opcode and reserved causes both use the opcode vector
        send_exc(2'd0, 32'd253, ae);
        send_exc(2'd3, 32'd253, ae);

        // 6: reset during EXC_READ
        exc_req   = 1'b1;
        exc_cause = 2'd2;
        ae = cyc;
        push_exp(ae + 1, 3'b000, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        push_exp(ae + 2, 3'b000, 1'b0, 1'b0, 1'b1, 32'd255, 1'b0);
        @(posedge clk); #1;
        exc_req = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("mrst_pc_write", {31'd0, PC_write},  32'd0);
        chk("mrst_epc",      {31'd0, EPC_write}, 32'd0);
        chk("mrst_vec_rd",   {31'd0, vec_rd},    32'd0);
        chk("mrst_vec_addr", vec_addr,           32'd0);
        chk("mrst_pc_src",   {29'd0, PC_src},    32'd0);
        chk("mrst_busy",     {31'd0, busy},      32'd0);
        chk("mrst_done",     {31'd0, done},      32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;

        // Recovery after reset
        send_req(2'd0, 1'b0, 3'b000, 1'b1, a1);
        wait_idle();
        repeat (8) @(negedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
